// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display blocks: active-low segment
// patterns (bit7=dp, bits6..0=g..a), scan digit indices and scan FSM states.
package seg_pkg;

  localparam logic [7:0] SEG_0    = 8'hC0;
  localparam logic [7:0] SEG_1    = 8'hF9;
  localparam logic [7:0] SEG_2    = 8'hA4;
  localparam logic [7:0] SEG_3    = 8'hB0;
  localparam logic [7:0] SEG_4    = 8'h99;
  localparam logic [7:0] SEG_5    = 8'h92;
  localparam logic [7:0] SEG_6    = 8'h82;
  localparam logic [7:0] SEG_7    = 8'hF8;
  localparam logic [7:0] SEG_8    = 8'h80;
  localparam logic [7:0] SEG_9    = 8'h90;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [7:0] SEG_OFF  = 8'hFF;

  localparam logic [1:0] IDX_SEC_UNIT = 2'd0;
  localparam logic [1:0] IDX_SEC_TEN  = 2'd1;
  localparam logic [1:0] IDX_MIN_UNIT = 2'd2;
  localparam logic [1:0] IDX_MIN_TEN  = 2'd3;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder (g..a); values above 9
// decode to a dash so a corrupted digit is visible rather than misleading.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    case (i_bcd)
      4'd0:    o_seg = SEG_0[6:0];
      4'd1:    o_seg = SEG_1[6:0];
      4'd2:    o_seg = SEG_2[6:0];
      4'd3:    o_seg = SEG_3[6:0];
      4'd4:    o_seg = SEG_4[6:0];
      4'd5:    o_seg = SEG_5[6:0];
      4'd6:    o_seg = SEG_6[6:0];
      4'd7:    o_seg = SEG_7[6:0];
      4'd8:    o_seg = SEG_8[6:0];
      4'd9:    o_seg = SEG_9[6:0];
      default: o_seg = SEG_DASH[6:0];
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed MM:SS driver for a 4-digit common-anode display, with an
// all-off guard interval between digits and adjust-mode blinking of one pair.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int GUARD    = 4,
  parameter int DP_DIGIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_en,
  input  logic       blink_en,
  input  logic       adj_en,
  input  logic       sel,
  input  logic [2:0] min_ten,
  input  logic [3:0] min_unit,
  input  logic [2:0] sec_ten,
  input  logic [3:0] sec_unit,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam int            CW         = (GUARD < 1) ? 1 : $clog2(GUARD + 1);
  localparam logic [CW-1:0] CNT_INIT   = CW'(GUARD);
  localparam logic [CW-1:0] CNT_RELOAD = CW'((GUARD > 0) ? GUARD - 1 : 0);

  scan_state_t   r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]    r_idx, w_idx_nxt;
  logic [3:0]    r_shadow, w_shadow_nxt;
  logic [3:0]    w_digit;
  logic          r_phase, w_phase_nxt;
  logic          w_advance, w_blank, w_dp_n;
  logic [6:0]    w_seg7;
  logic [7:0]    w_seg_nxt;
  logic [3:0]    w_an_nxt;

  // Outputs are registered from next-state values so the pins track the state the same edge.
  assign w_advance   = (r_state == SHOW) && scan_en;
  assign w_idx_nxt   = w_advance ? r_idx + 2'd1 : r_idx;
  assign w_phase_nxt = r_phase ^ blink_en;

  always_comb begin
    case (w_idx_nxt)
      IDX_SEC_UNIT: w_digit = sec_unit;
      IDX_SEC_TEN:  w_digit = {1'b0, sec_ten};
      IDX_MIN_UNIT: w_digit = min_unit;
      default:      w_digit = {1'b0, min_ten};
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shadow_nxt = r_shadow;
    case (r_state)
      BLANK: begin
        if (r_cnt == '0) begin
          w_state_nxt  = SHOW;
          w_shadow_nxt = w_digit;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      SHOW: begin
        if (w_advance && (GUARD == 0)) begin
          w_shadow_nxt = w_digit;
        end else if (w_advance) begin
          w_state_nxt = BLANK;
          w_cnt_nxt   = CNT_RELOAD;
        end else begin
          w_state_nxt = SHOW;
        end
      end
      default: begin
        w_state_nxt = BLANK;
        w_cnt_nxt   = CNT_INIT;
      end
    endcase
  end

  assign w_blank = adj_en & w_phase_nxt &
                   (sel ? (w_idx_nxt <= IDX_SEC_TEN) : (w_idx_nxt >= IDX_MIN_UNIT));
  assign w_dp_n  = (int'(w_idx_nxt) == DP_DIGIT) ? 1'b0 : 1'b1;

  bcd_to_seg u_dec (
    .i_bcd (w_shadow_nxt),
    .o_seg (w_seg7)
  );

  always_comb begin
    if (w_state_nxt == SHOW) begin
      w_an_nxt  = ~(4'b0001 << w_idx_nxt);
      w_seg_nxt = w_blank ? SEG_OFF : {w_dp_n, w_seg7};
    end else begin
      w_an_nxt  = 4'b1111;
      w_seg_nxt = SEG_OFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= BLANK;
      r_cnt    <= CNT_INIT;
      r_idx    <= IDX_SEC_UNIT;
      r_shadow <= 4'd0;
      r_phase  <= 1'b0;
      an       <= 4'b1111;
      seg      <= SEG_OFF;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_shadow <= w_shadow_nxt;
      r_phase  <= w_phase_nxt;
      an       <= w_an_nxt;
      seg      <= w_seg_nxt;
    end
  end

endmodule
